// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared parameters, state encoding and width helper for the priority pending encoder
package prio_enc_pkg;

  localparam int N_DEFAULT = 10;

  // State is implicit in valid: IDLE <=> valid=0, PRESENT <=> valid=1
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_pending_encoder_if.sv
// rtl/priority_pending_encoder_if.sv - request/mask/ack and index/valid/pending bundle
interface priority_pending_encoder_if
  import prio_enc_pkg::*;
#(
  parameter int N = N_DEFAULT
) ();

  localparam int IDX_W = clog2_min1(N);

  logic [N-1:0]     req;
  logic [N-1:0]     mask;
  logic             ack;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic [N-1:0]     pending;

  modport master (
    output req, mask, ack,
    input  idx, valid, pending
  );

  modport slave (
    input  req, mask, ack,
    output idx, valid, pending
  );

endinterface

// File: rtl/prio_find_highest.sv
// rtl/prio_find_highest.sv - combinational highest-set-bit finder, bit N-1 has top priority
module prio_find_highest
  import prio_enc_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  // Ascending scan: the last (highest) set bit overwrites earlier hits
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        index = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_pending_encoder.sv
// rtl/priority_pending_encoder.sv - registered priority encoder with pending storage and valid/ack
// PRIO_ENC_EDGE_EN: pend on rising edges of req instead of levels
module priority_pending_encoder
  import prio_enc_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  priority_pending_encoder_if.slave   bus
);

  localparam int IDX_W = clog2_min1(N);

  state_t           state_q, state_next;
  logic [IDX_W-1:0] idx_q, idx_next;
  logic [N-1:0]     pending_q, pending_next;
  logic [N-1:0]     set, clr, selectable;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             valid;

  assign valid = (state_q == PRESENT);

`ifdef PRIO_ENC_EDGE_EN
  logic [N-1:0] req_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= bus.req;
    end
  end

  assign set = bus.req & ~req_q;
`else
  assign set = bus.req;
`endif

  prio_find_highest #(.N(N), .IDX_W(IDX_W)) u_find (
    .vec   (selectable),
    .index (cand),
    .found (found)
  );

  always_comb begin
    clr          = '0;
    pending_next = pending_q;
    selectable   = '0;
    state_next   = state_q;
    idx_next     = idx_q;

    if (bus.ack && valid) begin
      clr = {{(N-1){1'b0}}, 1'b1} << idx_q;
    end
    // Set is OR-ed last so a same-cycle re-request survives the clear
    pending_next = (pending_q & ~clr) | set;
    selectable   = pending_next & ~bus.mask;

    if (!valid || bus.ack) begin
      state_next = found ? PRESENT : IDLE;
      idx_next   = found ? cand : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_next;
      idx_q     <= idx_next;
      pending_q <= pending_next;
    end
  end

  assign bus.idx     = idx_q;
  assign bus.valid   = valid;
  assign bus.pending = pending_q;

endmodule
